enqueue_splitter: RTL and testbench
===================================

Name: enqueue_splitter

Overview:
- Registered, parametrised successor to the serial link's combinational enqueue stage.
- Accepts one wide payload beat with byte strobe and computes the required number of BandWidth-sized splits from the highest set strobe byte.
- Buffers the beat, then emits the splits sequentially on a valid/ready stream, each tagged with first/last flags and split index.
- Sits between the link-layer packetizer and the physical channel allocator.

Parameters:
- DataWidth, 256, payload width in bits; must be a multiple of 8.
- BandWidth, 64, bits emitted per split.
- AllowVarLen, 1'b1, 1 = split count derived from strobe; 0 = always MaxSplits.
- MaxSplits (localparam), ceil(DataWidth/BandWidth), maximum splits per beat.
- StrbWidth (localparam), DataWidth/8.
- CntWidth (localparam), $clog2(MaxSplits+1).
- BitsWidth (localparam), $clog2(DataWidth+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  1  input beat valid.
- ready_o  out  1  input beat accepted when valid_i && ready_o.
- data_i  in  DataWidth  payload.
- strb_i  in  StrbWidth  byte strobe; bit k covers data_i[8k+7:8k].
- credits_only_i  in  1  beat carries credits only; forces one split.
- valid_o  out  1  split valid.
- ready_i  in  1  downstream ready.
- data_o  out  BandWidth  split payload.
- first_o  out  1  high on split 0.
- last_o  out  1  high on final split.
- split_idx_o  out  CntWidth  index of the current split.
- num_splits_o  out  CntWidth  split count of the current beat.
- remaining_bits_o  out  BitsWidth  payload bits of the current beat.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: valid_o=0, split counter=0, state IDLE, num_splits_o=0, remaining_bits_o=0. ready_o=1 in the cycle after reset.
- Reset mid-transfer: discard the buffered beat. Next cycle valid_o=0, ready_o=1. No partial split is emitted.
- States:
  - IDLE: ready_o=1, valid_o=0. On input handshake, capture data, credits_only, computed splits and bits; go to SEND with counter=0.
  - SEND: valid_o=1. Each output handshake increments the counter.
  - On the handshake of the last split: if valid_i is also high, capture the new beat in the same cycle, reset the counter to 0 and stay in SEND (zero-bubble back-to-back). Otherwise go to IDLE.
- ready_o = (state==IDLE) || (valid_o && ready_i && last_o). It is combinational from ready_i; no other path exists.
- Split computation (registered at capture, AllowVarLen=1):
  - h = index of highest set strb bit.
  - bits = 8*(h+1).
  - splits = ceil(bits/BandWidth).
  - Strobe all zero: bits=0, splits=1.
  - credits_only_i=1: splits=1 and bits=1, regardless of strobe.
- AllowVarLen=0: splits=MaxSplits and bits=DataWidth always. credits_only_i still forces 1 split.
- data_o = captured_data[idx*BandWidth +: BandWidth]. If DataWidth is not a multiple of BandWidth, the upper bits of the final split are zero-padded.
- first_o = (idx==0). last_o = (idx==num_splits-1). With 1 split, both are high together.
- Stall: while valid_o && !ready_i, all outputs are held stable. Valid is never withdrawn.
- Latency: first split appears 1 cycle after the input handshake.
- Throughput: 1 split per cycle under continuous ready_i.
- Data and strobe are not modified; bytes above the highest strobe byte are not transmitted.

Test Plan (DataWidth=256, BandWidth=64, MaxSplits=4):
- strb=0xFFFFFFFF, ready_i=1 -> 4 splits on consecutive cycles; data_o = data_i[63:0] .. data_i[255:192]; first_o on idx0, last_o on idx3; num_splits_o=4, remaining_bits_o=256.
- strb=0x0001FFFF (17 bytes) -> num_splits_o=3, remaining_bits_o=136; last_o on idx2. strb=0x000000FF -> 1 split with first_o=last_o=1, remaining_bits_o=64.
- credits_only_i=1 with strb=0xFFFFFFFF -> 1 split, remaining_bits_o=1. strb=0 with credits_only_i=0 -> 1 split, remaining_bits_o=0.
- ready_i=0 for 3 cycles at idx1 -> valid_o, data_o, idx and flags held stable; resumes at idx1 with no split skipped.
- Back-to-back beats A (4 splits) and B (2 splits), valid_i held high -> ready_o=1 only in A's idx3 handshake cycle; B idx0 follows next cycle; 6 splits in 6 cycles.
- rst_i asserted for 1 cycle during idx2 -> next cycle valid_o=0, ready_o=1; a new beat then starts at idx0. AllowVarLen=0 build with strb=0x1 -> 4 splits.

Source files
------------

// File: rtl/enqueue_splitter_if.sv
// Stream bundle for enqueue_splitter: one wide strobed beat in, BandWidth-sized
// tagged splits out. The slave modport is the splitter's view.
interface enqueue_splitter_if #(
    parameter int DataWidth = 256,
    parameter int BandWidth = 64
);
    localparam int MaxSplits = (DataWidth + BandWidth - 1) / BandWidth;
    localparam int StrbWidth = DataWidth / 8;
    localparam int CntWidth  = $clog2(MaxSplits + 1);
    localparam int BitsWidth = $clog2(DataWidth + 1);

    logic                 valid_i;
    logic                 ready_o;
    logic [DataWidth-1:0] data_i;
    logic [StrbWidth-1:0] strb_i;
    logic                 credits_only_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [BandWidth-1:0] data_o;
    logic                 first_o;
    logic                 last_o;
    logic [CntWidth-1:0]  split_idx_o;
    logic [CntWidth-1:0]  num_splits_o;
    logic [BitsWidth-1:0] remaining_bits_o;

    modport master (
        output valid_i, data_i, strb_i, credits_only_i, ready_i,
        input  ready_o, valid_o, data_o, first_o, last_o,
               split_idx_o, num_splits_o, remaining_bits_o
    );

    modport slave (
        input  valid_i, data_i, strb_i, credits_only_i, ready_i,
        output ready_o, valid_o, data_o, first_o, last_o,
               split_idx_o, num_splits_o, remaining_bits_o
    );
endinterface

// File: rtl/enqueue_splitter.sv
// Registered enqueue stage: buffers one wide beat and replays it as a sequence
// of BandWidth-sized splits, sized from the highest set strobe byte.
module enqueue_splitter #(
    parameter int DataWidth   = 256,
    parameter int BandWidth   = 64,
    parameter bit AllowVarLen = 1'b1
) (
    input logic               clk_i,
    input logic               rst_i,
    enqueue_splitter_if.slave bus
);
    localparam int MaxSplits = (DataWidth + BandWidth - 1) / BandWidth;
    localparam int StrbWidth = DataWidth / 8;
    localparam int CntWidth  = $clog2(MaxSplits + 1);
    localparam int BitsWidth = $clog2(DataWidth + 1);
    localparam int PadWidth  = MaxSplits * BandWidth;

    typedef enum logic {IDLE, SEND} state_e;

    state_e               state_q, state_d;
    logic [CntWidth-1:0]  idx_q, idx_d;
    logic [CntWidth-1:0]  nsplit_q, nsplit_d;
    logic [BitsWidth-1:0] bits_q, bits_d;
    logic [PadWidth-1:0]  data_q, data_d;

    logic [BitsWidth-1:0] calc_bits;
    logic [CntWidth-1:0]  calc_splits;
    logic                 capture;
    logic                 valid;
    logic                 last;
    logic                 out_hs;

    // Later (higher) strobe bits overwrite earlier ones, leaving the highest.
    always_comb begin
        calc_bits = '0;
        for (int k = 0; k < StrbWidth; k++) begin
            if (bus.strb_i[k]) calc_bits = BitsWidth'(8 * (k + 1));
        end
        calc_splits = CntWidth'((int'(calc_bits) + BandWidth - 1) / BandWidth);
        if (calc_bits == '0) calc_splits = CntWidth'(1);
        if (!AllowVarLen) begin
            calc_bits   = BitsWidth'(DataWidth);
            calc_splits = CntWidth'(MaxSplits);
        end
        if (bus.credits_only_i) begin
            calc_bits   = BitsWidth'(1);
            calc_splits = CntWidth'(1);
        end
    end

    assign valid  = (state_q == SEND);
    assign last   = (idx_q == nsplit_q - CntWidth'(1));
    assign out_hs = valid && bus.ready_i;

    // NOTE: every output default is assigned first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    capture = 1'b1;
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (out_hs) begin
                    if (!last) begin
                        idx_d = idx_q + CntWidth'(1);
                    end else begin
                        idx_d = '0;
                        if (bus.valid_i) capture = 1'b1;
                        else             state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        data_d   = capture ? PadWidth'(bus.data_i) : data_q;
        nsplit_d = capture ? calc_splits : nsplit_q;
        bits_d   = capture ? calc_bits : bits_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            nsplit_q <= '0;
            bits_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            nsplit_q <= nsplit_d;
            bits_q   <= bits_d;
        end
    end

    // NOTE: the payload buffer is left unreset; it is only observed while in SEND.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign bus.ready_o          = (state_q == IDLE) || (out_hs && last);
    assign bus.valid_o          = valid;
    assign bus.data_o           = data_q[int'(idx_q) * BandWidth +: BandWidth];
    assign bus.first_o          = (idx_q == '0);
    assign bus.last_o           = last;
    assign bus.split_idx_o      = idx_q;
    assign bus.num_splits_o     = nsplit_q;
    assign bus.remaining_bits_o = bits_q;
endmodule

// File: tb/tb_enqueue_splitter.sv
// Directed bench for enqueue_splitter: variable-length build plus a fixed-length
// build sharing clock and reset.
module tb_enqueue_splitter;
    localparam int DW = 256;
    localparam int BW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;

    always #5 clk = ~clk;

    enqueue_splitter_if #(.DataWidth(DW), .BandWidth(BW)) bus ();
    enqueue_splitter_if #(.DataWidth(DW), .BandWidth(BW)) bus_fix ();

    enqueue_splitter #(.DataWidth(DW), .BandWidth(BW), .AllowVarLen(1'b1)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    enqueue_splitter #(.DataWidth(DW), .BandWidth(BW), .AllowVarLen(1'b0)) dut_fix (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus_fix)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_split(input string nm, input logic [DW-1:0] d, input int i,
                               input int n, input int b);
        check({nm, " valid"}, bus.valid_o, 1'b1);
        check({nm, " idx"}, bus.split_idx_o, i);
        check({nm, " data"}, bus.data_o, d[i*BW +: BW]);
        check({nm, " first"}, bus.first_o, (i == 0));
        check({nm, " last"}, bus.last_o, (i == n - 1));
        check({nm, " nsplits"}, bus.num_splits_o, n);
        check({nm, " bits"}, bus.remaining_bits_o, b);
    endtask

    task automatic run_beat(input string nm, input logic [DW-1:0] d, input logic [31:0] s,
                            input logic c, input int n, input int b);
        bus.valid_i        = 1'b1;
        bus.data_i         = d;
        bus.strb_i         = s;
        bus.credits_only_i = c;
        bus.ready_i        = 1'b1;
        #1;
        check({nm, " ready_idle"}, bus.ready_o, 1'b1);
        tick();
        bus.valid_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            check_split(nm, d, i, n, b);
            tick();
        end
        check({nm, " done"}, bus.valid_o, 1'b0);
    endtask

    initial begin
        data_a = {64'hDDDD_4444_DDDD_4444, 64'hCCCC_3333_CCCC_3333,
                  64'hBBBB_2222_BBBB_2222, 64'hAAAA_1111_AAAA_1111};
        data_b = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  64'h5A5A_A5A5_0F0F_F0F0, 64'h1357_9BDF_2468_ACE0};

        bus.valid_i            = 1'b0;
        bus.data_i             = '0;
        bus.strb_i             = '0;
        bus.credits_only_i     = 1'b0;
        bus.ready_i            = 1'b1;
        bus_fix.valid_i        = 1'b0;
        bus_fix.data_i         = '0;
        bus_fix.strb_i         = '0;
        bus_fix.credits_only_i = 1'b0;
        bus_fix.ready_i        = 1'b1;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst valid", bus.valid_o, 1'b0);
        check("rst ready", bus.ready_o, 1'b1);
        check("rst nsplits", bus.num_splits_o, 0);
        check("rst bits", bus.remaining_bits_o, 0);
        check("rst idx", bus.split_idx_o, 0);

        // Strobe-derived lengths
        run_beat("full", data_a, 32'hFFFF_FFFF, 1'b0, 4, 256);
        run_beat("b17", data_b, 32'h0001_FFFF, 1'b0, 3, 136);
        run_beat("b8", data_a, 32'h0000_00FF, 1'b0, 1, 64);
        run_beat("cred", data_b, 32'hFFFF_FFFF, 1'b1, 1, 1);
        run_beat("zero", data_a, 32'h0000_0000, 1'b0, 1, 0);

        // Stall at idx1 for three cycles
        bus.valid_i        = 1'b1;
        bus.data_i         = data_a;
        bus.strb_i         = 32'hFFFF_FFFF;
        bus.credits_only_i = 1'b0;
        tick();
        bus.valid_i = 1'b0;
        tick();
        bus.ready_i = 1'b0;
        repeat (3) begin
            tick();
            check_split("stall", data_a, 1, 4, 256);
            check("stall ready", bus.ready_o, 1'b0);
        end
        bus.ready_i = 1'b1;
        #1;
        check_split("resume", data_a, 1, 4, 256);
        tick();
        check_split("resume", data_a, 2, 4, 256);
        tick();
        check_split("resume", data_a, 3, 4, 256);
        tick();
        check("resume done", bus.valid_o, 1'b0);

        // Back-to-back A (4 splits) then B (2 splits), valid held
        bus.valid_i = 1'b1;
        bus.data_i  = data_a;
        bus.strb_i  = 32'hFFFF_FFFF;
        tick();
        bus.data_i = data_b;
        bus.strb_i = 32'h0000_FFFF;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("b2b ready", bus.ready_o, (i == 3));
            check_split("b2b_a", data_a, i, 4, 256);
            tick();
        end
        bus.valid_i = 1'b0;
        check_split("b2b_b", data_b, 0, 2, 128);
        tick();
        check_split("b2b_b", data_b, 1, 2, 128);
        tick();
        check("b2b done", bus.valid_o, 1'b0);

        // Reset during idx2
        bus.valid_i = 1'b1;
        bus.data_i  = data_a;
        bus.strb_i  = 32'hFFFF_FFFF;
        tick();
        bus.valid_i = 1'b0;
        tick();
        tick();
        check("pre_rst idx", bus.split_idx_o, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst valid", bus.valid_o, 1'b0);
        check("mid_rst ready", bus.ready_o, 1'b1);
        check("mid_rst nsplits", bus.num_splits_o, 0);
        run_beat("post_rst", data_b, 32'hFFFF_FFFF, 1'b0, 4, 256);

        // Fixed-length build ignores a short strobe
        bus_fix.valid_i = 1'b1;
        bus_fix.data_i  = data_b;
        bus_fix.strb_i  = 32'h0000_0001;
        tick();
        bus_fix.valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("fix valid", bus_fix.valid_o, 1'b1);
            check("fix idx", bus_fix.split_idx_o, i);
            check("fix data", bus_fix.data_o, data_b[i*BW +: BW]);
            check("fix last", bus_fix.last_o, (i == 3));
            check("fix nsplits", bus_fix.num_splits_o, 4);
            check("fix bits", bus_fix.remaining_bits_o, 256);
            tick();
        end
        check("fix done", bus_fix.valid_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
